// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder : 8-digit hex seven-segment driver with an 8-entry distinct-value history
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decoder #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bin,
  output logic [7:0] seg,
  output logic [7:0] pnp
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [3:0]       bin_q, bin_d;
  logic [7:0][3:0]  hist_val_q, hist_val_d;
  logic [7:0]       hist_vld_q, hist_vld_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       dig_q, dig_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       pnp_q, pnp_d;
  logic             shift_en;
  logic             div_last;

  function automatic logic [7:0] seg_code(input logic [3:0] v);
    logic [7:0] c;
    case (v)
      4'h0: c = 8'hC0;
      4'h1: c = 8'hF9;
      4'h2: c = 8'hA4;
      4'h3: c = 8'hB0;
      4'h4: c = 8'h99;
      4'h5: c = 8'h92;
      4'h6: c = 8'h82;
      4'h7: c = 8'hF8;
      4'h8: c = 8'h80;
      4'h9: c = 8'h90;
      4'hA: c = 8'h88;
      4'hB: c = 8'h83;
      4'hC: c = 8'hC6;
      4'hD: c = 8'hA1;
      4'hE: c = 8'h86;
      default: c = 8'h8E;
    endcase
    return c;
  endfunction

  // History only moves when a new distinct sample shows up at the head
  assign shift_en = !hist_vld_q[0] || (bin_q != hist_val_q[0]);
  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    bin_d      = bin;
    hist_val_d = hist_val_q;
    hist_vld_d = hist_vld_q;
    div_d      = div_q + 1'b1;
    dig_d      = dig_q;
    seg_d      = 8'hFF;
    pnp_d      = 8'hFF;

    if (shift_en) begin
      hist_val_d = {hist_val_q[6:0], bin_q};
      hist_vld_d = {hist_vld_q[6:0], 1'b1};
    end

    if (div_last) begin
      div_d = '0;
      dig_d = dig_q + 3'd1;
    end

    // Output is driven from the pre-edge history and digit index
    if (hist_vld_q[dig_q]) begin
      seg_d = seg_code(hist_val_q[dig_q]);
      pnp_d = ~(8'd1 << dig_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q      <= '0;
      hist_val_q <= '0;
      hist_vld_q <= '0;
      div_q      <= '0;
      dig_q      <= '0;
      seg_q      <= 8'hFF;
      pnp_q      <= 8'hFF;
    end else begin
      bin_q      <= bin_d;
      hist_val_q <= hist_val_d;
      hist_vld_q <= hist_vld_d;
      div_q      <= div_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
      pnp_q      <= pnp_d;
    end
  end

  assign seg = seg_q;
  assign pnp = pnp_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder.sv
// ---------------------------------------------------------------------------
// tb_decoder : directed self-checking bench, three instances at REFRESH_DIV 4/1/3
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bin = 4'h0;
  logic [7:0] seg4, pnp4, seg1, pnp1, seg3, pnp3;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] cap_seg [8];
  logic [7:0] cap_mask;

  decoder #(.REFRESH_DIV(4)) u_dut4 (.clk(clk), .rst(rst), .bin(bin), .seg(seg4), .pnp(pnp4));
  decoder #(.REFRESH_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bin(bin), .seg(seg1), .pnp(pnp1));
  decoder #(.REFRESH_DIV(3)) u_dut3 (.clk(clk), .rst(rst), .bin(bin), .seg(seg3), .pnp(pnp3));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full frame of the REFRESH_DIV=1 instance, binned by enabled digit
  task automatic capture_frame();
    cap_mask = 8'h00;
    for (int i = 0; i < 8; i++) cap_seg[i] = 8'hFF;
    for (int c = 0; c < 8; c++) begin
      step();
      for (int i = 0; i < 8; i++) begin
        if (pnp1 == ~(8'd1 << i)) begin
          cap_seg[i]  = seg1;
          cap_mask[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=%h exp=%h", 8'h00, 8'h01);
    $fatal(1, "timeout");
  end

  initial begin
    int       blank_cnt;
    logic [7:0] last;
    logic [7:0] prev;
    logic     found;

    // ---- reset and first frame on the REFRESH_DIV=4 instance ----
    repeat (3) step();
    check("rst_seg", seg4, 8'hFF);
    check("rst_pnp", pnp4, 8'hFF);
    rst = 1'b0;
    step();
    check("rel_e1_pnp", pnp4, 8'hFF);
    step();
    check("rel_e2_seg", seg4, 8'hC0);
    check("rel_e2_pnp", pnp4, 8'hFE);
    step();
    step();
    check("rel_e4_pnp", pnp4, 8'hFE);
    blank_cnt = 0;
    for (int c = 0; c < 28; c++) begin
      step();
      if (pnp4 == 8'hFF && seg4 == 8'hFF) blank_cnt++;
    end
    check("blank_digits", 8'(blank_cnt), 8'd28);
    step();
    check("wrap_seg", seg4, 8'hC0);
    check("wrap_pnp", pnp4, 8'hFE);

    // ---- step 0..F, 10 cycles each, REFRESH_DIV=1 ----
    for (int v = 0; v < 16; v++) begin
      bin  = 4'(v);
      last = 8'h00;
      for (int c = 0; c < 10; c++) begin
        step();
        if (pnp1 == 8'hFE) last = seg1;
      end
      check($sformatf("dig0_val%0h", v), last, seg_tab[v]);
    end
    capture_frame();
    check("frame_mask", cap_mask, 8'hFF);
    for (int i = 0; i < 8; i++)
      check($sformatf("frame_dig%0d", i), cap_seg[i], seg_tab[15 - i]);

    // ---- 3, 4 then hold 5: no extra shift ----
    bin = 4'h3;
    repeat (10) step();
    bin = 4'h4;
    repeat (10) step();
    bin = 4'h5;
    repeat (100) step();
    capture_frame();
    check("hold_dig0", cap_seg[0], 8'h92);
    check("hold_dig1", cap_seg[1], 8'h99);
    check("hold_dig2", cap_seg[2], 8'hB0);
    check("hold_dig3", cap_seg[3], 8'h8E);

    // ---- scan timing, REFRESH_DIV=3, full history ----
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      prev = pnp3;
      step();
      if (prev == 8'h7F && pnp3 == 8'hFE) found = 1'b1;
    end
    check("scan_sync", {7'd0, found}, 8'h01);
    for (int c = 1; c <= 24; c++) begin
      step();
      check($sformatf("scan_c%0d", c), pnp3, ~(8'd1 << ((c / 3) % 8)));
    end

    // ---- asynchronous reset mid-scan ----
    #3;
    rst = 1'b1;
    #1;
    check("arst_seg3", seg3, 8'hFF);
    check("arst_pnp3", pnp3, 8'hFF);
    check("arst_pnp1", pnp1, 8'hFF);
    bin = 4'h1;
    step();
    step();
    check("arst_hold_pnp1", pnp1, 8'hFF);

    // ---- toggle 1/2 every cycle after release ----
    rst = 1'b0;
    step();
    check("post_rst_blank", pnp1, 8'hFF);
    bin = 4'h2;
    for (int k = 2; k <= 11; k++) begin
      step();
      bin = (k % 2 == 1) ? 4'h2 : 4'h1;
    end
    step();
    repeat (10) step();
    capture_frame();
    check("tog_mask", cap_mask, 8'hFF);
    for (int i = 0; i < 8; i++)
      check($sformatf("tog_dig%0d", i), cap_seg[i], (i % 2 == 0) ? 8'hA4 : 8'hF9);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
